// File: rtl/pll_reset_sequencer_pkg.sv
// pll_reset_sequencer_pkg: shared state encoding and counter sizing helpers.
package pll_reset_sequencer_pkg;

    typedef enum logic [2:0] {WAIT_LOCK, STABILIZE, RUN, HOLD, PLL_RST} state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic 2-flop bit synchroniser with async active-low reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q, sync_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: debounced system reset from PLL lock, with lock-loss counting.
// Optional lock timeout / PLL reset pulse enabled by PLL_RESET_SEQ_TIMEOUT_EN.
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int RESET_HOLD_CYCLES   = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int PLL_RESET_PULSE     = 8,
    parameter int LOSS_CNT_W          = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  locked_in,
    output logic                  sys_reset_n,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] lock_loss_count,
    output logic                  pll_resetb
);

    // One counter is shared by every timed state, so size it for the longest.
    localparam int CW = cnt_w(max2(max2(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES),
                                   max2(LOCK_TIMEOUT_CYCLES, PLL_RESET_PULSE)));
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(RESET_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LAST   = CW'(PLL_RESET_PULSE - 1);

    logic                  locked_s;
    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  sys_reset_n_q, sys_reset_n_d;
    logic                  lock_lost_q, lock_lost_d;
    logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

    sync_2ff #(.RESET_VAL(1'b0)) u_lock_sync (
        .clock  (clock),
        .reset_n(reset_n),
        .d      (locked_in),
        .q      (locked_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
                if (locked_s) begin
                    state_d = STABILIZE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                state_d = locked_s ? STABILIZE : WAIT_LOCK;
                cnt_d   = '0;
`endif
            end
            STABILIZE: begin
                // Lock drop takes priority over reaching the terminal count.
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
            PLL_RST: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
        sys_reset_n_d = (state_d == RUN);
        lock_lost_d   = (state_q == RUN) && !locked_s;
        loss_cnt_d    = (lock_lost_d && loss_cnt_q != '1) ? loss_cnt_q + 1'b1 : loss_cnt_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= WAIT_LOCK;
            cnt_q         <= '0;
            sys_reset_n_q <= 1'b0;
            lock_lost_q   <= 1'b0;
            loss_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sys_reset_n_q <= sys_reset_n_d;
            lock_lost_q   <= lock_lost_d;
            loss_cnt_q    <= loss_cnt_d;
        end
    end

`ifdef PLL_RESET_SEQ_TIMEOUT_EN
    logic pll_resetb_q, pll_resetb_d;

    assign pll_resetb_d = (state_d != PLL_RST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pll_resetb_q <= 1'b1;
        else          pll_resetb_q <= pll_resetb_d;
    end

    assign pll_resetb = pll_resetb_q;
`else
    assign pll_resetb = 1'b1;
`endif

    assign sys_reset_n     = sys_reset_n_q;
    assign ready           = sys_reset_n_q;
    assign lock_lost       = lock_lost_q;
    assign lock_loss_count = loss_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: scoreboard bench; expected output events queued by stimulus, popped by monitor.
module tb_pll_reset_sequencer;

    localparam int LSW = 2;

    typedef enum {EV_RISE, EV_FALL, EV_LOST, EV_PRISE, EV_PFALL} ev_e;
    typedef struct {
        ev_e kind;
        int  cyc;
        int  cnt;
    } exp_t;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           locked_in = 1'b0;
    logic           sys_reset_n, ready, lock_lost, pll_resetb;
    logic [LSW-1:0] lock_loss_count;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;
    bit   running = 0;
    exp_t sb[$];
    logic prev_srn = 1'b0;
    logic prev_pr = 1'b1;

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES (8),
        .RESET_HOLD_CYCLES  (4),
        .LOCK_TIMEOUT_CYCLES(20),
        .PLL_RESET_PULSE    (3),
        .LOSS_CNT_W         (LSW)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .locked_in      (locked_in),
        .sys_reset_n    (sys_reset_n),
        .ready          (ready),
        .lock_lost      (lock_lost),
        .lock_loss_count(lock_loss_count),
        .pll_resetb     (pll_resetb)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic push(input ev_e k, input int c, input int n);
        exp_t e;
        e.kind = k;
        e.cyc  = c;
        e.cnt  = n;
        sb.push_back(e);
    endtask

    task automatic chk_ev(input ev_e k);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL event %s: seen at cycle %0d count %0d, none expected", k.name(), cyc, lock_loss_count);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.cyc != cyc || e.cnt != int'(lock_loss_count) || ready !== sys_reset_n) begin
                n_fail++;
                $display("FAIL event %s: got cycle %0d count %0d ready %b, need %s cycle %0d count %0d ready %b",
                         k.name(), cyc, lock_loss_count, ready, e.kind.name(), e.cyc, e.cnt, sys_reset_n);
            end
        end
    endtask

    task automatic chk_val(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, need %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (sys_reset_n !== prev_srn) chk_ev(sys_reset_n ? EV_RISE : EV_FALL);
        if (lock_lost === 1'b1) chk_ev(EV_LOST);
        if (pll_resetb !== prev_pr) chk_ev(pll_resetb ? EV_PRISE : EV_PFALL);
        prev_srn = sys_reset_n;
        prev_pr  = pll_resetb;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_val({tag, "_sys_reset_n"}, int'(sys_reset_n), 0);
        chk_val({tag, "_ready"}, int'(ready), 0);
        chk_val({tag, "_lock_lost"}, int'(lock_lost), 0);
        chk_val({tag, "_count"}, int'(lock_loss_count), 0);
        chk_val({tag, "_pll_resetb"}, int'(pll_resetb), 1);
    endtask

    // Asserts reset between edges, checks outputs before any further edge, releases on a negedge.
    task automatic do_reset(input string tag, input logic lk);
        @(posedge clock);
        #2;
        if (running) push(EV_FALL, cyc, 0);
        running   = 0;
        exp_cnt   = 0;
        reset_n   = 1'b0;
        locked_in = lk;
        #1;
        chk_reset_vals(tag);
        tick(3);
        reset_n = 1'b1;
    endtask

    task automatic expect_release(input int edge0);
        push(EV_RISE, edge0 + 10, exp_cnt);
        running = 1;
    endtask

    initial begin
        int e0, a, r;
        tick(3);
        chk_reset_vals("por");
        reset_n = 1'b1;
        tick(2);

        locked_in = 1'b1;
        e0 = cyc + 1;
        expect_release(e0);
        tick(16);
        chk_val("basic_count", int'(lock_loss_count), 0);
        chk_val("basic_ready", int'(ready), 1);

        do_reset("deb", 1'b0);
        locked_in = 1'b1;
        tick(5);
        locked_in = 1'b0;
        tick(3);
        locked_in = 1'b1;
        e0 = cyc + 1;
        expect_release(e0);
        tick(16);
        chk_val("deb_count", int'(lock_loss_count), 0);

        for (int i = 0; i < 5; i++) begin
            locked_in = 1'b0;
            a = cyc + 1;
            tick(1);
            locked_in = 1'b1;
            exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
            push(EV_FALL, a + 2, exp_cnt);
            push(EV_LOST, a + 2, exp_cnt);
            push(EV_RISE, a + 15, exp_cnt);
            tick(20);
        end
        chk_val("sat_count", int'(lock_loss_count), 3);

        do_reset("run_abort", 1'b1);
        tick(6);
        do_reset("stab_abort", 1'b1);
        e0 = cyc + 1;
        expect_release(e0);
        tick(16);

        do_reset("to", 1'b0);
        r = cyc + 1;
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
        push(EV_PFALL, r + 19, 0);
        push(EV_PRISE, r + 22, 0);
        push(EV_PFALL, r + 42, 0);
        push(EV_PRISE, r + 45, 0);
`endif
        tick(50);
        chk_val("to_sys_reset_n", int'(sys_reset_n), 0);
        chk_val("to_count", int'(lock_loss_count), 0);
        chk_val("to_pll_resetb", int'(pll_resetb), (r + 48 > cyc) ? 0 : 1);

        tick(3);
        chk_val("sb_pending", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Consumes the PLL `locked` indication and produces a clean, debounced system reset for the QSPI test logic. It runs on the PLL reference clock (25 MHz board clock), so it operates even while the PLL output is absent. It synchronises `locked`, requires lock to be stable before releasing reset, re-asserts reset on any lock loss, and counts lock-loss events for debug. Consumers must synchronise `sys_reset_n` into their own PLL-output domain.

Parameters:
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-locked cycles required before reset release; must be ≥ 2.
- RESET_HOLD_CYCLES, 16: minimum cycles `sys_reset_n` stays low after a lock loss; must be ≥ 1.
- LOCK_TIMEOUT_CYCLES, 65536: cycles waiting for lock before a PLL reset pulse. Used only with the optional feature.
- PLL_RESET_PULSE, 8: cycles `pll_resetb` is held low. Used only with the optional feature.
- LOSS_CNT_W, 8: width of the lock-loss counter.

Ports:
- clock  input  1  PLL reference clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- locked_in  input  1  raw PLL lock flag; asynchronous to `clock`.
- sys_reset_n  output  1  registered system reset, active low.
- ready  output  1  high exactly when `sys_reset_n` is high.
- lock_lost  output  1  one-cycle pulse on each lock loss while in RUN.
- lock_loss_count  output  LOSS_CNT_W  saturating count of lock losses.
- pll_resetb  output  1  drives PLL RESETB; constant 1 without the optional feature.

Behaviour:
- Reset values (asserting `reset_n`):
  - `sys_reset_n`=0, `ready`=0, `lock_lost`=0, `lock_loss_count`=0, `pll_resetb`=1.
  - Synchronisers cleared, state=WAIT_LOCK, counters cleared.
  - Reset mid-operation aborts any state immediately and restores these values.
- Synchronisation: `locked_in` passes through a 2-flop synchroniser giving `locked_s`. FSM logic uses `locked_s` only.
- Edge numbering: edge 0 is the first edge that samples `locked_in`=1. `locked_s` is high after edge 1.
- WAIT_LOCK:
  - `locked_s`=1 → STABILIZE; clear the counter.
- STABILIZE:
  - Counter increments each cycle while `locked_s`=1.
  - `locked_s`=0 → WAIT_LOCK; counter cleared. No loss is counted here.
  - Counter == LOCK_STABLE_CYCLES-1 → RUN.
- RUN:
  - `sys_reset_n`=1 and `ready`=1, registered, so they are high from the edge entering RUN.
  - `locked_s`=0 → HOLD on the next edge. On that edge `sys_reset_n`=0, `lock_lost`=1 for one cycle, and the count saturates at all-ones.
- HOLD:
  - `sys_reset_n`=0 for exactly RESET_HOLD_CYCLES cycles, regardless of `locked_s`.
  - Then → WAIT_LOCK; the debounce restarts from zero.
- Release latency from edge 0: entry to STABILIZE at edge 2; `sys_reset_n` rises after edge 2+LOCK_STABLE_CYCLES.
- Simultaneous events: a lock drop on the same edge the counter reaches terminal count → WAIT_LOCK. Lock-drop wins.
- Glitches: a `locked_in` glitch shorter than one cycle may be missed or seen as a one-cycle drop. Both are legal.
- `lock_loss_count` never wraps.

Optional Feature:
- Macro: PLL_RESET_SEQ_TIMEOUT_EN.
- With the macro:
  - WAIT_LOCK also counts cycles while `locked_s`=0.
  - Count reaching LOCK_TIMEOUT_CYCLES → PLL_RST state: `pll_resetb`=0 for PLL_RESET_PULSE cycles, then → WAIT_LOCK with the timeout counter cleared.
  - PLL_RST keeps `sys_reset_n`=0 and does not increment `lock_loss_count`.
  - Entry to STABILIZE clears the timeout counter.
- Without the macro: no timeout counter, no PLL_RST state, `pll_resetb` tied to 1. Port list is unchanged.

Decomposition:
- Shared package: state enum (WAIT_LOCK, STABILIZE, RUN, HOLD, PLL_RST) and a clog2-based width constant/function for counters.
- One sub-module: sync_2ff, a generic 2-flop bit synchroniser with async active-low reset. It is reused later for crossing `sys_reset_n` into the PLL domain.

Test Plan:
- Basic release, LOCK_STABLE_CYCLES=8: `locked_in` rises and stays high → `sys_reset_n` and `ready` rise after edge 10, never earlier; `lock_lost` stays 0.
- Debounce: `locked_in` high for 5 cycles, low for 3, then high → release 10 edges after the second rise; count stays 0.
- Lock loss in RUN, RESET_HOLD_CYCLES=4: drop `locked_in` for 1 cycle → `sys_reset_n` falls, one `lock_lost` pulse, count=1. Reset stays low ≥ 4 cycles plus the 8-cycle debounce before re-release.
- Saturation, LOSS_CNT_W=2: 5 lock losses → count reads 1, 2, 3, 3, 3; `lock_lost` pulses 5 times.
- Async reset: assert `reset_n` in the middle of STABILIZE and in the middle of RUN → all outputs take reset values immediately, without waiting for a clock edge; after deassert, full 10-edge release with `locked_in` held high.
- Timeout (with macro, LOCK_TIMEOUT_CYCLES=20, PLL_RESET_PULSE=3): `locked_in` held 0 → `pll_resetb` low for exactly 3 cycles every 23 cycles. Without the macro, `pll_resetb` stays 1 throughout.
